bpu_resolve_update: RTL
=======================

// Module: bpu_resolve_update
// PURPOSE
// - EXE-side producer for the branch predictor: compares resolved branch outcome against the prediction carried down from pre_IF.
// - Raises a registered front-end redirect on mispredict.
// - Queues predictor write packets in a small FIFO and drains one per cycle into the predictor BTB write port.
// - Keeps branch and mispredict performance counters.
// PARAMETERS
// - QDEPTH     4   update FIFO entries; power of two, >=2
// - CNT_WD     32  perf counter width
// PORTS
// clk               in   1   clock
// resetn            in   1   asynchronous, active-low reset
// ex_valid          in   1   EXE presents a resolved branch/jump this cycle
// ex_ready          out  1   block can accept; = !fifo_full
// ex_pc             in   32  PC of branch instruction
// ex_target         in   32  actual taken target
// ex_taken          in   1   actual direction
// ex_pred_taken     in   1   direction predicted at pre_IF
// ex_pred_target    in   32  target predicted at pre_IF
// ex_pred_hit       in   1   BTB hit at pre_IF
// ex_pred_type      in   2   2-bit counter state read at pre_IF
// ex_is_call        in   1   call (JAL/JALR with link)
// ex_is_return      in   1   return (JR $31)
// redirect_valid    out  1   one-cycle pulse: flush front end
// redirect_pc       out  32  fetch restart PC
// upd_valid         out  1   head entry valid (= !fifo_empty)
// upd_ready         in   1   predictor accepts write this cycle
// upd_pc            out  32  head: branch PC (write index/tag)
// upd_branch_pc     out  32  head: actual target
// upd_taken         out  1   head: actual direction (predictor result input)
// upd_hit           out  1   head: pre_IF hit flag
// upd_type          out  2   head: counter state from pre_IF
// upd_is_call/upd_is_return out 1 each  head call/return flags
// perf_branches     out  CNT_WD  accepted branches
// perf_mispredicts  out  CNT_WD  mispredicts
// BEHAVIOUR
// - Accept: acc = ex_valid & ex_ready. Inputs are ignored when acc=0.
// - Mispredict, combinational on inputs: mis = acc & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_target != ex_target)).
// - Redirect: registered, latency 1 cycle.
//   - redirect_valid <= mis.
//   - redirect_pc <= ex_taken ? ex_target : ex_pc + 32'd8 (delay slot skipped; 32-bit add, wrap mod 2^32).
//   - redirect_pc holds its value when redirect_valid=0.
// - FIFO:
//   - acc pushes {ex_pc, ex_target, ex_taken, ex_pred_hit, ex_pred_type, call, return}.
//   - Pop when upd_valid & upd_ready.
//   - Head fields always come from storage; there is no bypass. An entry pushed into an empty FIFO appears on upd_* the next cycle.
//   - Full: ex_ready=0 (push rejected even if a pop occurs the same cycle).
//   - Simultaneous push+pop when neither full nor empty: count is unchanged.
//   - Pointers wrap modulo QDEPTH; an extra wrap bit distinguishes full from empty.
//   - Drain order is strict FIFO, no coalescing. Entries are never dropped by redirect; only committed branches reach EXE.
//   - upd_* fields are don't-care while upd_valid=0, but must be stable while upd_valid=1 & upd_ready=0.
// - Counters:
//   - perf_branches += acc; perf_mispredicts += mis.
//   - Both saturate at all-ones (no wrap).
// - Reset (async assert, any cycle including mid-drain):
//   - redirect_valid=0, redirect_pc=0.
//   - FIFO pointers=0, so upd_valid=0 and ex_ready=1.
//   - Both perf counters=0.
//   - Storage contents are not reset.
// STRUCTURE
// - Shared define header BPU_define.v holds widths and counter encodings (WEAKLY_NT, WEAKLY_T, STRONGLY_T, STRONGLY_NT).
// - Add to that header: UPD_WD (packet width) and packet field slices.
// - One sub-module: bpu_upd_fifo (parameterised QDEPTH x UPD_WD sync FIFO with full/empty/push/pop).
// - Compare/redirect/counter logic stays in the top module.
// TESTING
// - Correct predict: pc=0x1000, taken=1, pred_taken=1, target=pred_target=0x2000 -> no redirect; perf_branches=1, perf_mispredicts=0; upd_valid next cycle with upd_pc=0x1000.
// - Direction mispredict: pc=0x1000, taken=0, pred_taken=1 -> next cycle redirect_valid=1 (1 cycle), redirect_pc=0x1008; perf_mispredicts=1.
// - Target mispredict: taken=1, pred_taken=1, target=0x3000, pred_target=0x2000 -> redirect_pc=0x3000.
// - Backpressure: upd_ready=0, push 4 branches -> ex_ready=0 after 4th; 5th ex_valid is ignored; raise upd_ready -> 4 pops in push order, one per cycle, fields held while stalled.
// - Boundary: pc=0xFFFFFFFC not-taken mispredict -> redirect_pc=0x00000004; counter preset near saturation (CNT_WD=4 build) stops at 4'hF.
// - Reset: assert resetn=0 mid-drain with 3 queued -> upd_valid=0, ex_ready=1, counters=0, redirect_valid=0 immediately (async).

Source files
------------

// File: rtl/bpu_resolve_update_pkg.sv
// Shared widths, counter encodings and the update-packet layout for the
// branch-resolve / predictor-update block.
//   ADDR_WD      : PC / target width
//   CTR_WD       : 2-bit direction counter width
//   ctr_state_e  : counter encodings read at pre_IF
//   upd_pkt_t    : one predictor write packet (field order = bit slices)
//   UPD_WD       : packet width in bits
package bpu_resolve_update_pkg;

    localparam int ADDR_WD = 32;
    localparam int CTR_WD  = 2;

    typedef enum logic [CTR_WD-1:0] {
        STRONGLY_NT = 2'b00,
        WEAKLY_NT   = 2'b01,
        WEAKLY_T    = 2'b10,
        STRONGLY_T  = 2'b11
    } ctr_state_e;

    // Packed MSB-first: pc[69:38], target[37:6], taken[5], hit[4],
    // ctr[3:2], is_call[1], is_return[0].
    typedef struct packed {
        logic [ADDR_WD-1:0] pc;
        logic [ADDR_WD-1:0] target;
        logic               taken;
        logic               hit;
        ctr_state_e         ctr;
        logic               is_call;
        logic               is_return;
    } upd_pkt_t;

    localparam int UPD_WD = $bits(upd_pkt_t);

    // Fall-through fetch address: skip the branch and its delay slot.
    function automatic logic [ADDR_WD-1:0] fall_through_pc(input logic [ADDR_WD-1:0] pc);
        return pc + 32'd8;
    endfunction

endpackage

// File: rtl/bpu_resolve_update_if.sv
// EXE-side resolve bus plus predictor update-write bus.
//   master : environment (EXE stage drives ex_*, predictor drives upd_ready)
//   slave  : bpu_resolve_update
interface bpu_resolve_update_if;
    import bpu_resolve_update_pkg::*;

    logic               ex_valid;
    logic               ex_ready;
    logic [ADDR_WD-1:0] ex_pc;
    logic [ADDR_WD-1:0] ex_target;
    logic               ex_taken;
    logic               ex_pred_taken;
    logic [ADDR_WD-1:0] ex_pred_target;
    logic               ex_pred_hit;
    logic [CTR_WD-1:0]  ex_pred_type;
    logic               ex_is_call;
    logic               ex_is_return;

    logic               upd_valid;
    logic               upd_ready;
    logic [ADDR_WD-1:0] upd_pc;
    logic [ADDR_WD-1:0] upd_branch_pc;
    logic               upd_taken;
    logic               upd_hit;
    logic [CTR_WD-1:0]  upd_type;
    logic               upd_is_call;
    logic               upd_is_return;

    modport master (
        output ex_valid, ex_pc, ex_target, ex_taken, ex_pred_taken,
               ex_pred_target, ex_pred_hit, ex_pred_type, ex_is_call, ex_is_return,
               upd_ready,
        input  ex_ready, upd_valid, upd_pc, upd_branch_pc, upd_taken, upd_hit,
               upd_type, upd_is_call, upd_is_return
    );

    modport slave (
        input  ex_valid, ex_pc, ex_target, ex_taken, ex_pred_taken,
               ex_pred_target, ex_pred_hit, ex_pred_type, ex_is_call, ex_is_return,
               upd_ready,
        output ex_ready, upd_valid, upd_pc, upd_branch_pc, upd_taken, upd_hit,
               upd_type, upd_is_call, upd_is_return
    );

endinterface

// File: rtl/bpu_resolve_update_fifo.sv
// Synchronous FIFO for predictor update packets. No bypass: dout is always
// read from storage. Storage is not reset; only the pointers are.
//   clk, resetn : clock, async active-low reset
//   push, din   : write (caller must not push when full)
//   pop, dout   : read head (caller must not pop when empty)
//   full, empty : status
module bpu_resolve_update_fifo #(
    parameter int DEPTH = 4,
    parameter int WD    = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic [WD-1:0] din,
    input  logic          pop,
    output logic [WD-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WD-1:0] mem [DEPTH];
    // Extra MSB is the wrap bit that separates full from empty.
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign dout  = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/bpu_resolve_update.sv
// EXE-side branch resolve: compares the resolved outcome with the pre_IF
// prediction, issues a registered redirect on mispredict, queues predictor
// update packets and keeps saturating performance counters.
//   clk, resetn      : clock, async active-low reset
//   bus              : resolve input (ex_*) and update output (upd_*)
//   redirect_valid   : one-cycle front-end flush pulse
//   redirect_pc      : fetch restart PC (held between pulses)
//   perf_branches    : accepted branch count (saturating)
//   perf_mispredicts : mispredict count (saturating)
module bpu_resolve_update
    import bpu_resolve_update_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int CNT_WD = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    bpu_resolve_update_if.slave  bus,
    output logic                 redirect_valid,
    output logic [ADDR_WD-1:0]   redirect_pc,
    output logic [CNT_WD-1:0]    perf_branches,
    output logic [CNT_WD-1:0]    perf_mispredicts
);
    logic     fifo_full;
    logic     fifo_empty;
    logic     acc;
    logic     mis;
    logic     pop;
    upd_pkt_t push_pkt;
    upd_pkt_t head_pkt;

    assign bus.ex_ready = !fifo_full;
    assign acc          = bus.ex_valid && !fifo_full;
    assign pop          = !fifo_empty && bus.upd_ready;

    // Target only matters when the branch was actually taken.
    assign mis = acc && ((bus.ex_taken != bus.ex_pred_taken) ||
                         (bus.ex_taken && (bus.ex_pred_target != bus.ex_target)));

    always_comb begin
        push_pkt           = '0;
        push_pkt.pc        = bus.ex_pc;
        push_pkt.target    = bus.ex_target;
        push_pkt.taken     = bus.ex_taken;
        push_pkt.hit       = bus.ex_pred_hit;
        push_pkt.ctr       = ctr_state_e'(bus.ex_pred_type);
        push_pkt.is_call   = bus.ex_is_call;
        push_pkt.is_return = bus.ex_is_return;
    end

    bpu_resolve_update_fifo #(
        .DEPTH (QDEPTH),
        .WD    (UPD_WD)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (acc),
        .din    (push_pkt),
        .pop    (pop),
        .dout   (head_pkt),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign bus.upd_valid     = !fifo_empty;
    assign bus.upd_pc        = head_pkt.pc;
    assign bus.upd_branch_pc = head_pkt.target;
    assign bus.upd_taken     = head_pkt.taken;
    assign bus.upd_hit       = head_pkt.hit;
    assign bus.upd_type      = head_pkt.ctr;
    assign bus.upd_is_call   = head_pkt.is_call;
    assign bus.upd_is_return = head_pkt.is_return;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= mis;
            if (mis) redirect_pc <= bus.ex_taken ? bus.ex_target : fall_through_pc(bus.ex_pc);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (acc && (perf_branches != {CNT_WD{1'b1}}))
                perf_branches <= perf_branches + CNT_WD'(1);
            if (mis && (perf_mispredicts != {CNT_WD{1'b1}}))
                perf_mispredicts <= perf_mispredicts + CNT_WD'(1);
        end
    end

endmodule
